// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared seven-segment types and the hex glyph table
package hex_display_pkg;

    // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_digits_scan_driver_if.sv
// rtl/hex_digits_scan_driver_if.sv - value/control in, multiplexed display lines out
//   value       : 4*NUM_DIGITS hex value, digit 0 in value[3:0]
//   enable      : 1 = scan, 0 = display dark
//   lz_blank    : 1 = suppress leading zeros
//   seg_n       : segments {g,f,e,d,c,b,a}, active-low
//   dp_n        : decimal point, active-low
//   an_n        : digit anodes, active-low
//   frame_start : one-cycle pulse at the start of each scan frame
interface hex_digits_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    import hex_display_pkg::*;

    logic [4*NUM_DIGITS-1:0] value;
    logic                    enable;
    logic                    lz_blank;
    seg7_t                   seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    modport master (
        output value, enable, lz_blank,
        input  seg_n, dp_n, an_n, frame_start
    );

    modport slave (
        input  value, enable, lz_blank,
        output seg_n, dp_n, an_n, frame_start
    );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low seven-segment glyph
//   nibble_i : 4-bit hex digit
//   seg_o    : active-low {g,f,e,d,c,b,a} pattern
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG_PATTERNS[nibble_i];

endmodule

// File: rtl/hex_digits_scan_driver.sv
// rtl/hex_digits_scan_driver.sv - frame-latched, time-multiplexed 7-segment scanner
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of hex_digits_scan_driver_if (value/enable/lz_blank in,
//           seg_n/dp_n/an_n/frame_start out, all outputs registered)
module hex_digits_scan_driver
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                     clk,
    input  logic                     reset,
    hex_digits_scan_driver_if.slave  bus
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  lz_q, lz_d;
    seg7_t                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic [3:0]            cur_nibble;
    seg7_t                 cur_seg;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic                  at_frame_start;

    assign cur_nibble = shadow_q[4*int'(idx_q) +: 4];

    hex_to_seg7 u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    // lz_mask[i] is set when nibble i and every nibble above it are zero.
    // Digit 0 is never part of the mask so a zero value still shows "0".
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    assign at_frame_start = (cnt_q == '0) && (idx_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        lz_d     = lz_q;
        seg_d    = SEG_BLANK;
        an_d     = '1;
        fs_d     = 1'b0;

        if (bus.enable) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Latching only at slot (0,0) keeps a frame internally consistent.
            if (at_frame_start) begin
                shadow_d = bus.value;
                lz_d     = bus.lz_blank;
            end

            fs_d = at_frame_start;

            // Dead time at the head of each slot hides anode/segment skew.
            if ((cnt_q >= CNT_W'(BLANK_CYCLES)) && !(lz_q && lz_mask[idx_q])) begin
                seg_d        = cur_seg;
                an_d[idx_q]  = 1'b0;
            end
        end else begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            lz_q     <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            lz_q     <= lz_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.seg_n       = seg_q;
    assign bus.an_n        = an_q;
    assign bus.frame_start = fs_q;
    assign bus.dp_n        = 1'b1;

endmodule
